// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: run handshake, jump controls and PC/stack status.
// master drives controls and target; slave returns prog_ctr and status.
`timescale 1ns/1ps
interface fetch_sequencer_if #(
  parameter int D = 12,
  parameter int S = 4
);
  localparam int DW = $clog2(S + 1);

  logic          req;
  logic          stall;
  logic          reljump_en;
  logic          absjump_en;
  logic          call_en;
  logic          ret_en;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic [DW-1:0] stk_depth;
  logic          stk_err;

  modport master (
    output req, stall, reljump_en, absjump_en,
    output call_en, ret_en, target,
    input  prog_ctr, running, done,
    input  stk_depth, stk_err
  );

  modport slave (
    input  req, stall, reljump_en, absjump_en,
    input  call_en, ret_en, target,
    output prog_ctr, running, done,
    output stk_depth, stk_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, IDLE/RUN/DONE run control and call/return stack.
// Ports: clk, reset (sync, active-high), bus (fetch_sequencer_if.slave).
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int D          = 12,
  parameter int S          = 4,
  parameter int HALT_ADDR  = 128,
  parameter int START_ADDR = 0
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.slave  bus
);
  localparam int DW = $clog2(S + 1);
  localparam int AW = (S > 1) ? $clog2(S) : 1;
  localparam logic [D-1:0]  HALT  = D'(HALT_ADDR);
  localparam logic [D-1:0]  START = D'(START_ADDR);
  localparam logic [DW-1:0] FULL  = DW'(S);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [D-1:0]  pc;
  logic [D-1:0]  stk [S];
  logic [DW-1:0] depth;
  logic          err;
  logic          running_q;
  logic          done_q;

  logic [D-1:0]  pc_inc;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;

  assign pc_inc   = pc + D'(1);
  // push_idx is only used when depth < S, so truncation is safe
  assign push_idx = AW'(depth);
  assign pop_idx  = AW'(depth - DW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= START;
      depth     <= '0;
      err       <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pc <= START;
          if (bus.req) begin
            state     <= RUN;
            running_q <= 1'b1;
            depth     <= '0;
            err       <= 1'b0;
          end
        end
        RUN: begin
          if (pc == HALT) begin
            state     <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (!bus.stall) begin
            if (bus.ret_en) begin
              if (depth != '0) begin
                pc    <= stk[pop_idx];
                depth <= depth - DW'(1);
              end else begin
                pc  <= pc_inc;
                err <= 1'b1;
              end
            end else if (bus.call_en) begin
              pc <= bus.target;
              if (depth != FULL) begin
                stk[push_idx] <= pc_inc;
                depth         <= depth + DW'(1);
              end else begin
                err <= 1'b1;
              end
            end else if (bus.absjump_en) begin
              pc <= bus.target;
            end else if (bus.reljump_en) begin
              pc <= pc + bus.target;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        DONE: begin
          // err stays visible until the next IDLE->RUN
          if (!bus.req) begin
            state  <= IDLE;
            done_q <= 1'b0;
            pc     <= START;
            depth  <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          pc        <= START;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_ctr  = pc;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.stk_depth = depth;
  assign bus.stk_err   = err;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table, hand sequences and random run
// checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam int D     = 12;
  localparam int S     = 4;
  localparam int HALT  = 128;
  localparam int START = 0;
  localparam int DW    = $clog2(S + 1);
  localparam int MOD   = 1 << D;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.D(D), .S(S)) bus();

  fetch_sequencer #(
    .D(D), .S(S), .HALT_ADDR(HALT), .START_ADDR(START)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 run, 2 done
  int           m_state;
  logic [D-1:0] m_pc;
  logic [D-1:0] m_stk[$];
  bit           m_err;

  function automatic logic [D-1:0] wrap(int v);
    return D'(((v % MOD) + MOD) % MOD);
  endfunction

  task automatic model_clock(input bit rst, input bit req,
                             input bit stall, input bit rel,
                             input bit abs_j, input bit call,
                             input bit ret, input logic [D-1:0] tgt);
    int off;
    if (rst) begin
      m_state = 0;
      m_pc    = D'(START);
      m_stk.delete();
      m_err   = 0;
      return;
    end
    case (m_state)
      0: begin
        m_pc = D'(START);
        if (req) begin
          m_state = 1;
          m_stk.delete();
          m_err = 0;
        end
      end
      1: begin
        if (int'(m_pc) == HALT) begin
          m_state = 2;
        end else if (!stall) begin
          if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
              m_err = 1;
              m_pc  = wrap(int'(m_pc) + 1);
            end
          end else if (call) begin
            if (m_stk.size() < S)
              m_stk.push_back(wrap(int'(m_pc) + 1));
            else
              m_err = 1;
            m_pc = tgt;
          end else if (abs_j) begin
            m_pc = tgt;
          end else if (rel) begin
            off  = tgt[D-1] ? int'(tgt) - MOD : int'(tgt);
            m_pc = wrap(int'(m_pc) + off);
          end else begin
            m_pc = wrap(int'(m_pc) + 1);
          end
        end
      end
      default: begin
        if (!req) begin
          m_state = 0;
          m_pc    = D'(START);
          m_stk.delete();
        end
      end
    endcase
  endtask

  task automatic apply(input bit rst, input bit req, input bit stall,
                       input bit rel, input bit abs_j, input bit call,
                       input bit ret, input logic [D-1:0] tgt);
    reset          = rst;
    bus.req        = req;
    bus.stall      = stall;
    bus.reljump_en = rel;
    bus.absjump_en = abs_j;
    bus.call_en    = call;
    bus.ret_en     = ret;
    bus.target     = tgt;
    @(posedge clk);
    model_clock(rst, req, stall, rel, abs_j, call, ret, tgt);
    #1;
  endtask

  task automatic check_exp(input string name, input logic [D-1:0] pc,
                           input bit run, input bit dn,
                           input int dep, input bit err);
    total++;
    if (bus.prog_ctr !== pc || bus.running !== run ||
        bus.done !== dn || bus.stk_depth !== DW'(dep) ||
        bus.stk_err !== err) begin
      bad++;
      $display("FAIL %s: got pc=%h run=%b done=%b dep=%0d err=%b want pc=%h run=%b done=%b dep=%0d err=%b",
               name, bus.prog_ctr, bus.running, bus.done,
               bus.stk_depth, bus.stk_err, pc, run, dn, dep, err);
    end
  endtask

  task automatic check_model(input string name);
    check_exp(name, m_pc, m_state == 1, m_state == 2,
              m_stk.size(), m_err);
  endtask

  // run step with req=1 and only the named controls
  task automatic run_step(input bit stall, input bit rel,
                          input bit abs_j, input bit call,
                          input bit ret, input logic [D-1:0] tgt,
                          input string name);
    apply(0, 1, stall, rel, abs_j, call, ret, tgt);
    check_model(name);
  endtask

  typedef struct {
    bit           stall, rel, abs_j, call, ret;
    logic [D-1:0] tgt;
    logic [D-1:0] pc;
    int           dep;
    bit           err;
  } vec_t;

  function automatic vec_t mk(bit st, bit rl, bit ab, bit cl, bit rt,
                              int tg, int pc, int dep, bit err);
    vec_t v;
    v.stall = st; v.rel = rl; v.abs_j = ab; v.call = cl; v.ret = rt;
    v.tgt = D'(tg); v.pc = D'(pc); v.dep = dep; v.err = err;
    return v;
  endfunction

  vec_t vt[17];

  initial begin
    int cyc;
    bit rq;
    vt[0]  = mk(0,1,0,0,0, 'hFFD,   7,   0, 0);
    vt[1]  = mk(0,1,0,0,0, 5,       12,  0, 0);
    vt[2]  = mk(0,0,1,0,0, 20,      20,  0, 0);
    vt[3]  = mk(0,0,0,1,0, 100,     100, 1, 0);
    vt[4]  = mk(0,0,0,0,0, 0,       101, 1, 0);
    vt[5]  = mk(0,0,0,0,0, 0,       102, 1, 0);
    vt[6]  = mk(0,0,0,0,1, 0,       21,  0, 0);
    vt[7]  = mk(0,0,1,0,0, 10,      10,  0, 0);
    vt[8]  = mk(0,1,1,0,0, 40,      40,  0, 0);
    vt[9]  = mk(1,0,1,0,0, 99,      40,  0, 0);
    vt[10] = mk(0,0,0,1,1, 200,     41,  0, 1);
    vt[11] = mk(0,0,0,1,0, 'hFFF,   'hFFF, 1, 1);
    vt[12] = mk(0,0,0,1,0, 5,       5,   2, 1);
    vt[13] = mk(0,0,0,0,1, 0,       0,   1, 1);
    vt[14] = mk(0,0,0,0,1, 0,       42,  0, 1);
    vt[15] = mk(0,1,0,0,0, 'hFFF,   41,  0, 1);
    vt[16] = mk(0,0,0,0,0, 0,       42,  0, 1);

    apply(1, 0, 0, 0, 0, 0, 0, '0);
    check_exp("reset", 0, 0, 0, 0, 0);
    apply(0, 0, 1, 1, 1, 1, 1, 12'd77);
    check_exp("idle_ignores", 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, '0);
    check_exp("first_run", 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) run_step(0,0,0,0,0, '0, "walk10");

    for (int i = 0; i < 17; i++) begin
      apply(0, 1, vt[i].stall, vt[i].rel, vt[i].abs_j,
            vt[i].call, vt[i].ret, vt[i].tgt);
      check_exp($sformatf("vec%0d", i), vt[i].pc, 1, 0,
                vt[i].dep, vt[i].err);
    end

    run_step(0,0,1,0,0, D'(HALT), "jump_halt");
    apply(0, 1, 0, 0, 0, 0, 0, '0);
    check_exp("done", D'(HALT), 0, 1, 0, 1);
    apply(0, 1, 0, 1, 1, 1, 0, 12'd9);
    check_exp("done_hold", D'(HALT), 0, 1, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, '0);
    check_exp("idle_err_held", 0, 0, 0, 0, 1);
    apply(0, 1, 0, 0, 0, 0, 0, '0);
    check_exp("rerun_clr", 0, 1, 0, 0, 0);

    // default linear run to the halt address
    for (int i = 1; i <= HALT; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, '0);
      check_exp("linear", D'(i), 1, 0, 0, 0);
    end
    apply(0, 1, 0, 0, 0, 0, 0, '0);
    check_exp("linear_done", D'(HALT), 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, '0);
    check_exp("linear_idle", 0, 0, 0, 0, 0);

    // overflow / underflow
    apply(0, 1, 0, 0, 0, 0, 0, '0);
    check_model("ov_start");
    for (int i = 0; i < 5; i++)
      run_step(0,0,0,1,0, D'(300 + 100 * i), "ov_call");
    check_exp("ov_full", 12'd700, 1, 0, 4, 1);
    run_step(0,0,0,0,1, '0, "ov_ret");
    check_exp("ov_lifo", 12'd501, 1, 0, 3, 1);
    for (int i = 0; i < 3; i++) run_step(0,0,0,0,1, '0, "ov_ret");
    check_exp("ov_last", 12'd1, 1, 0, 0, 1);
    run_step(0,0,0,0,1, '0, "uf_ret");
    check_exp("underflow", 12'd2, 1, 0, 0, 1);
    run_step(0,0,1,0,0, D'(HALT), "ov_halt");
    apply(0, 1, 0, 0, 0, 0, 0, '0);
    check_model("ov_done");
    apply(0, 0, 0, 0, 0, 0, 0, '0);
    check_exp("ov_idle", 0, 0, 0, 0, 1);
    apply(0, 1, 0, 0, 0, 0, 0, '0);
    check_exp("ov_clear", 0, 1, 0, 0, 0);

    // stall
    run_step(0,0,1,0,0, 12'd30, "st_go");
    for (int i = 0; i < 3; i++) run_step(1,0,1,0,0, 12'd99, "stall");
    check_exp("stall_hold", 12'd30, 1, 0, 0, 0);
    run_step(0,0,0,0,0, '0, "st_rel");
    check_exp("stall_release", 12'd31, 1, 0, 0, 0);

    // reset mid-run
    run_step(0,0,0,0,1, '0, "rm_uf");
    run_step(0,0,0,1,0, 12'd40, "rm_c1");
    run_step(0,0,0,1,0, 12'd50, "rm_c2");
    check_exp("rm_pre", 12'd50, 1, 0, 2, 1);
    apply(1, 1, 0, 0, 0, 1, 0, 12'd7);
    check_exp("rm_reset", 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, '0);
    check_exp("rm_idle", 0, 0, 0, 0, 0);

    // random against the model
    for (cyc = 0; cyc < 4000; cyc++) begin
      rq = (m_state == 2) ? bit'($urandom_range(0, 1))
                          : bit'($urandom_range(0, 9) < 9);
      apply(bit'($urandom_range(0, 299) == 0), rq,
            bit'($urandom_range(0, 4) == 0),
            bit'($urandom_range(0, 5) == 0),
            bit'($urandom_range(0, 6) == 0),
            bit'($urandom_range(0, 6) == 0),
            bit'($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0) ? D'(HALT) : D'($urandom));
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised successor to the core's program-counter and run-control logic.
- Holds a D-bit program counter with a req/done run handshake, relative and absolute jumps, and a call/return stack of configurable depth.
- Feeds prog_ctr to instr_ROM; takes its jump controls and target from the decoder and PC_LUT.
- Replaces the combinational "prog_ctr == 128" done detect with a registered, parametrised halt.

Parameters:
D, 12, program counter width
S, 4, return-stack depth (entries, >=1)
HALT_ADDR, 128, PC value that ends a run
START_ADDR, 0, PC value loaded at reset and on return to idle

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
req  input  1  run request; level-sensitive
stall  input  1  freeze all RUN-state updates this cycle
reljump_en  input  1  PC <= PC + target (signed)
absjump_en  input  1  PC <= target
call_en  input  1  push PC+1, PC <= target
ret_en  input  1  PC <= popped address
target  input  D  jump/call target or signed offset
prog_ctr  output  D  current instruction address
running  output  1  high in RUN
done  output  1  high in DONE
stk_depth  output  $clog2(S+1)  current stack occupancy
stk_err  output  1  sticky stack overflow/underflow flag

Behaviour:
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset, synchronous and dominant over all other inputs:
  - state = IDLE, prog_ctr = START_ADDR.
  - stack emptied, stk_depth = 0, stk_err = 0.
  - running = 0, done = 0.
  - Reset mid-run gives the same result the next cycle.
- State IDLE:
  - prog_ctr held at START_ADDR; jump, stall and stack inputs ignored.
  - req=1 -> RUN next cycle. On this transition stk_err is cleared and the stack emptied.
  - The first RUN cycle presents START_ADDR.
- State RUN:
  - running = 1.
  - If prog_ctr == HALT_ADDR: go to DONE next cycle, prog_ctr held. All jump/stack inputs are ignored this cycle, regardless of stall.
  - Else if stall = 1: prog_ctr, stack and stk_err all hold.
  - Else next PC is chosen by fixed priority:
    1. ret_en: stack non-empty -> PC <= top entry, depth - 1. Stack empty -> stk_err <= 1, PC <= PC + 1.
    2. call_en: PC <= target. Stack not full -> push PC + 1, depth + 1. Stack full -> no push, depth stays S, stk_err <= 1; the jump still occurs.
    3. absjump_en: PC <= target.
    4. reljump_en: PC <= PC + target, with target as D-bit two's complement, result modulo 2^D.
    5. Otherwise: PC <= PC + 1, wrapping from 2^D - 1 to 0.
  - Lower-priority enables asserted together with a higher one are ignored. ret_en + call_en in the same cycle performs the return only.
  - Pushed return addresses are D bits and wrap like the PC (call at 2^D - 1 pushes 0).
- State DONE:
  - done = 1, running = 0, prog_ctr held at HALT_ADDR.
  - Stack contents and stk_err are held for inspection.
  - req=1 -> stay in DONE.
  - req=0 -> IDLE next cycle; prog_ctr = START_ADDR, stack emptied, stk_err held until the next IDLE->RUN.
- Stack is LIFO with S entries and depth in 0..S; stk_depth always equals the number of valid entries.
- Latency: a control input in RUN cycle n affects prog_ctr in cycle n+1.

Test Plan:
- Defaults. Reset, req=1 held, no jumps -> prog_ctr 0,1,2,…,128 with running=1. Next cycle done=1, running=0, prog_ctr=128. Drop req -> next cycle IDLE, prog_ctr=0, done=0.
- Relative jumps. At PC=10 with reljump_en, target=12'hFFD -> PC=7. At PC=7 with target=5 -> PC=12. At PC=10, absjump_en+reljump_en with target=40 -> PC=40 (abs wins).
- Call/return. Call at PC=20, target=100 -> PC=100, stk_depth=1. Advance to 102, ret_en -> PC=21, stk_depth=0, stk_err=0.
- Overflow/underflow, S=4. Five nested calls -> 5th jumps to its target, stk_depth=4, stk_err=1. Four rets return in LIFO order; 5th ret on empty -> PC+1, stk_err stays 1. Next req cycle from IDLE clears stk_err.
- Stall. At PC=30, stall=1 for 3 cycles with absjump_en=1, target=99 -> PC stays 30, depth unchanged. Release stall, no enables -> PC=31.
- Reset mid-run. At PC=50, depth=2, stk_err=1, assert reset one cycle -> PC=0, IDLE, depth=0, stk_err=0, running=0, done=0.
